// File: rtl/r2sdf_bf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage.
// Pairs complex samples DELAY apart through a feedback delay line. The line
// holds the first half of a frame during the fill phase, and then holds the
// differences during the butterfly phase. Those differences drain during the
// next frame's fill phase. Results are DATA_W+1 bits wide, so no overflow occurs.
// Optional feature: define R2SDF_SOF_EN to add the out_sof frame marker.
module r2sdf_bf_stage #(
  parameter int DATA_W = 8,
  parameter int DELAY  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  output logic signed [DATA_W:0]   out_re,
  output logic signed [DATA_W:0]   out_im
`ifdef R2SDF_SOF_EN
  ,
  output logic                     out_sof
`endif
);

  localparam int CW = $clog2(2 * DELAY);

  logic [CW-1:0]          cnt;
  logic                   primed;
  logic                   phase;
  logic                   emit;
  logic signed [DATA_W:0] dl_re [DELAY];
  logic signed [DATA_W:0] dl_im [DELAY];
  logic signed [DATA_W:0] x_re, x_im;
  logic signed [DATA_W:0] head_re, head_im;
  logic signed [DATA_W:0] push_re, push_im;
  logic signed [DATA_W:0] res_re, res_im;

  // Phase is the counter MSB: 0 = fill, 1 = butterfly.
  assign phase = cnt[CW-1];
  // A result is produced once any butterfly has run. Until then, fill outputs would be stale zeros.
  assign emit  = in_valid & (primed | phase);

  // Butterfly datapath: sign-extend the input, then add or subtract the oldest entry.
  always_comb begin
    x_re    = {in_re[DATA_W-1], in_re};
    x_im    = {in_im[DATA_W-1], in_im};
    head_re = dl_re[DELAY-1];
    head_im = dl_im[DELAY-1];
    res_re  = head_re;
    res_im  = head_im;
    push_re = x_re;
    push_im = x_im;
    if (phase) begin
      res_re  = head_re + x_re;
      res_im  = head_im + x_im;
      push_re = head_re - x_re;
      push_im = head_im - x_im;
    end
  end

  // Phase counter and sticky primed flag; both are frozen during input gaps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      primed <= 1'b0;
    end else if (in_valid) begin
      cnt <= cnt + CW'(1);
      if (phase) primed <= 1'b1;
    end
  end

  // Feedback delay line; entry 0 is the newest and entry DELAY-1 is the head.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
    end else if (in_valid) begin
      dl_re[0] <= push_re;
      dl_im[0] <= push_im;
      for (int i = 1; i < DELAY; i++) begin
        dl_re[i] <= dl_re[i-1];
        dl_im[i] <= dl_im[i-1];
      end
    end
  end

  // Registered outputs; the data holds its last value while out_valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      out_valid <= emit;
      if (emit) begin
        out_re <= res_re;
        out_im <= res_im;
      end
    end
  end

`ifdef R2SDF_SOF_EN
  // Frame marker on the first sum, which is the first butterfly-phase sample.
  always_ff @(posedge clk) begin
    if (!rst_n) out_sof <= 1'b0;
    else        out_sof <= in_valid && (cnt == CW'(DELAY));
  end
`endif

endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// Scoreboard bench for r2sdf_bf_stage: one DELAY=2 instance and one DELAY=1 instance.
module tb_r2sdf_bf_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic rst_q = 1'b0;
  int   cyc   = 0;

  logic              v2 = 1'b0, v1 = 1'b0;
  logic signed [7:0] re2 = '0, im2 = '0, re1 = '0, im1 = '0;
  logic              ov2, ov1;
  logic signed [8:0] ore2, oim2, ore1, oim1;
  logic              sof2, sof1;

  r2sdf_bf_stage #(.DATA_W(8), .DELAY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_re(re2), .in_im(im2),
    .out_valid(ov2), .out_re(ore2), .out_im(oim2)
`ifdef R2SDF_SOF_EN
    , .out_sof(sof2)
`endif
  );

  r2sdf_bf_stage #(.DATA_W(8), .DELAY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_re(re1), .in_im(im1),
    .out_valid(ov1), .out_re(ore1), .out_im(oim1)
`ifdef R2SDF_SOF_EN
    , .out_sof(sof1)
`endif
  );

`ifndef R2SDF_SOF_EN
  assign sof2 = 1'b0;
  assign sof1 = 1'b0;
`endif

  typedef struct {
    int                d;
    int                cyc;
    logic signed [8:0] re;
    logic signed [8:0] im;
    logic              sof;
  } exp_t;

  exp_t              q[$];
  int                checks   = 0;
  int                failures = 0;
  logic signed [8:0] prev_re [2] = '{9'sd0, 9'sd0};
  logic signed [8:0] prev_im [2] = '{9'sd0, 9'sd0};

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  task automatic send(input int d, input int xr, input int xi, input bit ev,
                      input int er, input int ei, input bit es, input int gap);
    exp_t e;
    if (d == 0) begin v2 = 1'b1; re2 = 8'(xr); im2 = 8'(xi); end
    else        begin v1 = 1'b1; re1 = 8'(xr); im1 = 8'(xi); end
    if (ev) begin
      e.d = d; e.cyc = cyc + 1; e.re = 9'(er); e.im = 9'(ei); e.sof = es;
      q.push_back(e);
    end
    @(posedge clk); #1;
    v2 = 1'b0; v1 = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic mon(input int d, input logic v, input logic signed [8:0] r,
                     input logic signed [8:0] i, input logic s);
    int idx = -1;
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].d == d) begin idx = k; break; end
    end
    if (v) begin
      checks++;
      if (idx < 0) begin
        failures++;
        $display("FAIL unexpected_out dut%0d cyc=%0d got re=%0d im=%0d, required no output", d, cyc, r, i);
      end else begin
`ifdef R2SDF_SOF_EN
        if (q[idx].cyc != cyc || q[idx].re != r || q[idx].im != i || q[idx].sof != s) begin
`else
        if (q[idx].cyc != cyc || q[idx].re != r || q[idx].im != i) begin
`endif
          failures++;
          $display("FAIL out_sample dut%0d got cyc=%0d re=%0d im=%0d sof=%0b, required cyc=%0d re=%0d im=%0d sof=%0b",
                   d, cyc, r, i, s, q[idx].cyc, q[idx].re, q[idx].im, q[idx].sof);
        end
        q.delete(idx);
      end
    end else begin
      if (idx >= 0 && q[idx].cyc <= cyc) begin
        failures++;
        $display("FAIL missed_out dut%0d cyc=%0d got no output, required re=%0d im=%0d at cyc=%0d",
                 d, cyc, q[idx].re, q[idx].im, q[idx].cyc);
        q.delete(idx);
      end
      if (rst_q) begin
        checks++;
        if (r != prev_re[d] || i != prev_im[d]) begin
          failures++;
          $display("FAIL hold dut%0d cyc=%0d got re=%0d im=%0d, required re=%0d im=%0d",
                   d, cyc, r, i, prev_re[d], prev_im[d]);
        end
      end
    end
    prev_re[d] = r;
    prev_im[d] = i;
  endtask

  // Monitor, away from the active edge.
  always @(negedge clk) begin
    mon(0, ov2, ore2, oim2, sof2);
    mon(1, ov1, ore1, oim1, sof1);
  end

  task automatic check_reset(input int d, input logic v, input logic signed [8:0] r,
                             input logic signed [8:0] i, input logic s);
    checks++;
    if (v !== 1'b0 || r !== 9'sd0 || i !== 9'sd0 || s !== 1'b0) begin
      failures++;
      $display("FAIL reset_state dut%0d got v=%b re=%0d im=%0d sof=%b, required all zero", d, v, r, i, s);
    end
  endtask

  int xin  [3][8] = '{'{1, 2, 3, 4, 0, 0, 0, 0},
                      '{127, -128, 127, 127, 0, 0, 0, 0},
                      '{1, 2, 3, 4, 0, 0, 0, 0}};
  int eout [3][8] = '{'{0, 0, 4, 6, -2, -2, 0, 0},
                      '{0, 0, 254, -1, 0, -255, 0, 0},
                      '{0, 0, 4, 6, -2, -2, 0, 0}};
  bit esof [8]    = '{0, 0, 1, 0, 0, 0, 1, 0};
  int gaps [3]    = '{0, 0, 3};

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset(0, ov2, ore2, oim2, sof2);
    check_reset(1, ov1, ore1, oim1, sof1);
    rst_n = 1'b1;

    // Basic frame, then range, then gapped basic. Each scenario is followed by a zero flush frame.
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 8; k++)
        send(0, xin[s][k], 0, !(s == 0 && k < 2), eout[s][k], 0, esof[k], gaps[s]);

    // Partial frame, then reset; the 9s must leave no trace.
    send(0, 9, 0, 1, 0, 0, 0, 0);
    send(0, 9, 0, 1, 0, 0, 0, 0);
    send(0, 9, 0, 1, 18, 0, 1, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset(0, ov2, ore2, oim2, sof2);
    rst_n = 1'b1;
    send(0, 1, 0, 0, 0, 0, 0, 0);
    send(0, 2, 0, 0, 0, 0, 0, 0);
    send(0, 3, 0, 1, 4, 0, 1, 0);
    send(0, 4, 0, 1, 6, 0, 0, 1);

    // Imaginary path, DELAY=1.
    send(1, 0, 5, 0, 0, 0, 0, 0);
    send(1, 0, -3, 1, 0, 2, 1, 0);
    send(1, 0, 0, 1, 0, 8, 0, 0);
    send(1, 0, 0, 1, 0, 0, 1, 0);

    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d outstanding expected outputs, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
